// File: rtl/ws2812_stream.sv
// ws2812_stream: byte FIFO with hysteresis throttle feeding a WS2812
// serializer. Bytes go out MSB-first. Symbol timing and the latch length
// are set by parameters. Each frame ends with a latch period and then a
// one-cycle frame_done pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_LATCH | dout low for T_RESET cycles (power-up / end of frame)
//   S_IDLE  | dout low, waiting for the FIFO to hold a byte
//   S_BIT   | shifting out symbols of the byte held in sh
module ws2812_stream #(
  parameter int DEPTH     = 32,
  parameter int T0H       = 5,
  parameter int T1H       = 10,
  parameter int T_BIT     = 16,
  parameter int T_RESET   = 1024,
  parameter int HI_THRESH = 20,
  parameter int LO_THRESH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   throttle,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   dout,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = (T_RESET > 1) ? $clog2(T_RESET) : 1;
  localparam int SW = $clog2(T_BIT);

  localparam logic [FW-1:0] FULL       = FW'(DEPTH);
  localparam logic [FW-1:0] HI_F       = FW'(HI_THRESH);
  localparam logic [FW-1:0] LO_F       = FW'(LO_THRESH);
  localparam logic [CW-1:0] LATCH_LAST = CW'(T_RESET - 1);
  localparam logic [SW-1:0] SYM_LAST   = SW'(T_BIT - 1);
  localparam logic [SW-1:0] T0H_S      = SW'(T0H);
  localparam logic [SW-1:0] T1H_S      = SW'(T1H);

  localparam logic [1:0] S_LATCH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_BIT   = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic          push;
  logic          pop;

  logic [1:0]    state, nxt_state;
  logic [CW-1:0] cnt, nxt_cnt;
  logic          post_frame, nxt_post_frame;
  logic [7:0]    sh, nxt_sh;
  logic [2:0]    bitcnt, nxt_bitcnt;
  logic [SW-1:0] symcnt, nxt_symcnt;
  logic          nxt_dout;
  logic          nxt_frame_done;

  assign in_ready = (fill != FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign busy     = (state != S_IDLE);

  // FIFO storage; writes are gated by in_ready, which is low during reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr] <= in_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr   <= '0;
      rd   <= '0;
      fill <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop)  rd <= rd + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FW'(1);
        2'b01:   fill <= fill - FW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Throttle with hysteresis, driven from the registered fill.
  always_ff @(posedge clk) begin
    if (rst)              throttle <= 1'b0;
    else if (fill > HI_F) throttle <= 1'b1;
    else if (fill < LO_F) throttle <= 1'b0;
  end

  // Next-state logic. dout is computed from the next state so the line
  // itself comes straight from a flop.
  always_comb begin
    nxt_state      = state;
    nxt_cnt        = cnt;
    nxt_post_frame = post_frame;
    nxt_sh         = sh;
    nxt_bitcnt     = bitcnt;
    nxt_symcnt     = symcnt;
    nxt_frame_done = 1'b0;
    pop            = 1'b0;
    case (state)
      S_LATCH: begin
        if (cnt == LATCH_LAST) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
          if (post_frame) begin
            nxt_frame_done = 1'b1;
            nxt_post_frame = 1'b0;
          end
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (fill != '0) begin
          pop        = 1'b1;
          nxt_sh     = mem[rd];
          nxt_bitcnt = 3'd7;
          nxt_symcnt = '0;
          nxt_state  = S_BIT;
        end
      end
      S_BIT: begin
        if (symcnt == SYM_LAST) begin
          nxt_symcnt = '0;
          if (bitcnt != 3'd0) begin
            nxt_bitcnt = bitcnt - 3'd1;
          end else if (fill != '0) begin
            // Next byte is waiting: continue without any gap.
            pop        = 1'b1;
            nxt_sh     = mem[rd];
            nxt_bitcnt = 3'd7;
          end else begin
            // Underrun at a byte boundary closes the frame.
            nxt_post_frame = 1'b1;
            nxt_state      = S_LATCH;
            nxt_cnt        = '0;
          end
        end else begin
          nxt_symcnt = symcnt + SW'(1);
        end
      end
      default: begin
        nxt_state = S_LATCH;
        nxt_cnt   = '0;
      end
    endcase
    nxt_dout = (nxt_state == S_BIT) &&
               (nxt_symcnt < (nxt_sh[nxt_bitcnt] ? T1H_S : T0H_S));
  end

  // Serializer registers; reset restarts the latch and drops any byte in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LATCH;
      cnt        <= '0;
      post_frame <= 1'b0;
      sh         <= '0;
      bitcnt     <= '0;
      symcnt     <= '0;
      dout       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      post_frame <= nxt_post_frame;
      sh         <= nxt_sh;
      bitcnt     <= nxt_bitcnt;
      symcnt     <= nxt_symcnt;
      dout       <= nxt_dout;
      frame_done <= nxt_frame_done;
    end
  end

endmodule

// File: tb/tb_ws2812_stream.sv
// Testbench for ws2812_stream: decodes the dout waveform into high widths,
// rise times and frame_done times, then compares them to frames expected
// from the bytes pushed.
module tb_ws2812_stream;

  localparam int DEPTH   = 32;
  localparam int T0H     = 5;
  localparam int T1H     = 10;
  localparam int T_BIT   = 16;
  localparam int T_RESET = 1024;
  localparam int HI      = 20;
  localparam int LO      = 10;

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, throttle, dout, busy, frame_done;
  logic [5:0] fill;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rel0 = 0;
  int rise_q[$];
  int hiw_q[$];
  int fd_q[$];
  int rise_t = 0;
  logic prev_dout = 1'b0;

  ws2812_stream #(
    .DEPTH(DEPTH), .T0H(T0H), .T1H(T1H), .T_BIT(T_BIT),
    .T_RESET(T_RESET), .HI_THRESH(HI), .LO_THRESH(LO)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .throttle(throttle), .fill(fill), .dout(dout),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // waveform monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (dout && !prev_dout) begin
      rise_t <= cyc;
      rise_q.push_back(cyc);
    end
    if (!dout && prev_dout) hiw_q.push_back(cyc - rise_t);
    if (frame_done) fd_q.push_back(cyc);
    prev_dout <= dout;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    rise_q.delete();
    hiw_q.delete();
    fd_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    tick();
    check_eq("rst_fill", int'(fill), 0);
    check_eq("rst_dout", int'(dout), 0);
    check_eq("rst_thr", int'(throttle), 0);
    check_eq("rst_fd", int'(frame_done), 0);
    check_eq("rst_busy", int'(busy), 1);
    check_eq("rst_ready", int'(in_ready), 0);
    rst = 1'b0;
    in_valid = 1'b0;
    clear_log();
    rel0 = cyc + 1;
    tick();
    check_eq("rst_push_ignored", int'(fill), 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic acc;
    int g;
    g = 0;
    in_data = b;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      tick();
      g++;
    end while (!acc && g < 2000);
    in_valid = 1'b0;
    if (!acc) check_eq("push_timeout", 0, 1);
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int g;
    g = 0;
    while (fd_q.size() < n && g < budget) begin
      tick();
      g++;
    end
    check_eq(tag, fd_q.size(), n);
  endtask

  // frames: b holds all bytes in order, fl the byte count of each frame
  task automatic check_frames(input string tag, input bq_t b, input iq_t fl);
    int idx, bi, d, start;
    logic [7:0] cur;
    idx = 0;
    bi = 0;
    check_eq({tag, "_nsym"}, rise_q.size(), 8 * b.size());
    check_eq({tag, "_nhi"}, hiw_q.size(), 8 * b.size());
    check_eq({tag, "_nfd"}, fd_q.size(), fl.size());
    foreach (fl[f]) begin
      start = idx;
      for (int k = 0; k < fl[f]; k++) begin
        cur = b[bi];
        for (int j = 7; j >= 0; j--) begin
          if (idx < hiw_q.size())
            check_eq({tag, "_hi"}, hiw_q[idx], cur[j] ? T1H : T0H);
          if (idx != start && idx < rise_q.size())
            check_eq({tag, "_period"}, rise_q[idx] - rise_q[idx-1], T_BIT);
          idx++;
        end
        bi++;
      end
      if (idx > 0 && idx <= rise_q.size() && f < fd_q.size()) begin
        d = fd_q[f] - (rise_q[idx-1] + T_BIT);
        check_eq({tag, "_fd_delay"}, (d >= T_RESET - 1 && d <= T_RESET + 1) ? T_RESET : d, T_RESET);
      end
      if (f > 0 && start < rise_q.size() && f - 1 < fd_q.size())
        check_eq({tag, "_new_frame_after_latch"}, int'(rise_q[start] > fd_q[f-1]), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    iq_t fl;
    int g, pf, d, acc_n, mf, n, endt;
    logic te, chk_next, acc;
    logic [7:0] vals[64];

    // 1: single byte 0xA5 after reset
    do_reset();
    push_byte(8'hA5);
    wait_fd(1, 4000, "s1_fd");
    if (rise_q.size() > 0) begin
      d = rise_q[0] - rel0;
      check_eq("s1_first_rise", (d >= T_RESET && d <= T_RESET + 2) ? T_RESET + 1 : d, T_RESET + 1);
    end else check_eq("s1_first_rise", -1, T_RESET + 1);
    b = {8'hA5};
    fl = {1};
    check_frames("s1", b, fl);
    tick();
    check_eq("s1_busy_idle", int'(busy), 0);
    check_eq("s1_dout_idle", int'(dout), 0);

    // 2: three contiguous bytes
    do_reset();
    b = {8'h00, 8'hFF, 8'h81};
    foreach (b[i]) push_byte(b[i]);
    wait_fd(1, 4000, "s2_fd");
    fl = {3};
    check_frames("s2", b, fl);

    // 2b: random-length random frame
    do_reset();
    n = $urandom_range(2, 10);
    b.delete();
    for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    foreach (b[i]) push_byte(b[i]);
    wait_fd(1, 4000, "s2b_fd");
    fl = {n};
    check_frames("s2b", b, fl);

    // 3: throttle hysteresis
    do_reset();
    b.delete();
    for (int k = 1; k <= 21; k++) begin
      b.push_back(8'($urandom));
      push_byte(b[k-1]);
      check_eq("s3_fill_up", int'(fill), k);
      check_eq("s3_thr_up", int'(throttle), 0);
    end
    tick();
    check_eq("s3_thr_rise", int'(throttle), 1);
    pf = int'(fill);
    te = 1'b1;
    chk_next = 1'b0;
    g = 0;
    while (fd_q.size() == 0 && g < 6000) begin
      tick();
      g++;
      if (pf > HI) te = 1'b1;
      else if (pf < LO) te = 1'b0;
      if (int'(fill) != pf || chk_next) check_eq("s3_thr_drain", int'(throttle), int'(te));
      chk_next = (int'(fill) != pf);
      pf = int'(fill);
    end
    check_eq("s3_thr_end", int'(throttle), 0);
    fl = {21};
    check_frames("s3", b, fl);

    // 4: overfill and pointer wrap
    do_reset();
    foreach (vals[i]) vals[i] = 8'($urandom);
    acc_n = 0;
    mf = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      in_data = vals[acc_n];
      acc = in_ready;
      tick();
      if (acc) acc_n++;
      if (int'(fill) > mf) mf = int'(fill);
    end
    in_valid = 1'b0;
    check_eq("s4_accepted", acc_n, 32);
    check_eq("s4_fill_full", int'(fill), 32);
    check_eq("s4_ready_full", int'(in_ready), 0);
    check_eq("s4_max_fill", mf, 32);
    g = 0;
    while (rise_q.size() == 0 && g < 1200) begin
      tick();
      g++;
    end
    check_eq("s4_started", int'(rise_q.size() > 0), 1);
    for (int i = 32; i < 64; i++) push_byte(vals[i]);
    wait_fd(1, 10000, "s4_fd");
    b.delete();
    foreach (vals[i]) b.push_back(vals[i]);
    fl = {64};
    check_frames("s4", b, fl);

    // 5: late byte starts a new frame after the latch
    do_reset();
    push_byte(8'h0F);
    g = 0;
    while (hiw_q.size() < 8 && g < 1500) begin
      tick();
      g++;
    end
    check_eq("s5_first_byte", hiw_q.size(), 8);
    endt = (rise_q.size() >= 8) ? rise_q[7] + T_BIT : cyc;
    while (cyc < endt + 20) tick();
    push_byte(8'hF0);
    wait_fd(2, 3000, "s5_fd");
    b = {8'h0F, 8'hF0};
    fl = {1, 1};
    check_frames("s5", b, fl);

    // 6: reset mid-byte
    do_reset();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    g = 0;
    while (rise_q.size() < 5 && g < 1500) begin
      tick();
      g++;
    end
    check_eq("s6_reached_bit3", int'(rise_q.size() >= 5), 1);
    if (rise_q.size() >= 5) while (cyc < rise_q[4] + 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("s6_dout", int'(dout), 0);
    check_eq("s6_fill", int'(fill), 0);
    check_eq("s6_thr", int'(throttle), 0);
    tick();
    clear_log();
    for (int i = 0; i < 1000; i++) tick();
    check_eq("s6_busy_latch", int'(busy), 1);
    for (int i = 0; i < 100; i++) tick();
    check_eq("s6_busy_idle", int'(busy), 0);
    check_eq("s6_no_fd", fd_q.size(), 0);
    check_eq("s6_no_rise", rise_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ws2812_stream.md
Name: ws2812_stream

Overview:
- Parametrised successor to the fixed 32-byte buffer and WS2812 serializer currently inlined in Top.
- Accepts a byte stream (normally from the Uart receive path) through a valid/ready handshake and buffers it in a DEPTH-entry FIFO.
- Serializes bytes MSB-first onto a single WS2812 data line. All symbol timings, reset/latch length and throttle hysteresis are set by parameters.
- Adds a registered throttle with configurable thresholds, frame-end detection with a latch period, a frame_done pulse, a fill level output and synchronous reset.

Parameters:
DEPTH, 32, FIFO entries; power of two, >= 4
T0H, 5, clk cycles dout is high for a 0 bit
T1H, 10, clk cycles dout is high for a 1 bit; T0H < T1H < T_BIT
T_BIT, 16, clk cycles per bit symbol
T_RESET, 1024, clk cycles dout is held low for reset/latch
HI_THRESH, 20, throttle asserts when fill > HI_THRESH
LO_THRESH, 10, throttle deasserts when fill < LO_THRESH; LO_THRESH < HI_THRESH < DEPTH

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_data  in  8  byte to buffer
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready
throttle  out  1  flow-control request toward the upstream Uart
fill  out  clog2(DEPTH)+1  current FIFO occupancy
dout  out  1  WS2812 data line
busy  out  1  serializer is not in IDLE
frame_done  out  1  one-cycle pulse when the latch period after a frame completes

Behaviour:
- Reset (rst high at a clk edge):
  - FIFO pointers and fill go to 0; throttle=0, dout=0, frame_done=0.
  - State goes to LATCH with its counter at 0, and a "post-frame" flag is cleared.
  - Pushes presented in the same cycle are ignored.
  - Reset mid-byte aborts the byte immediately: dout=0 from the next cycle.
- FIFO:
  - in_ready = (fill != DEPTH) && !rst, combinational.
  - A push writes mem[wr] and increments wr. A pop reads mem[rd] combinationally and increments rd. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave fill unchanged.
  - A pop only occurs when fill > 0. A push when full cannot occur because in_ready=0.
- throttle (registered, updated every cycle from the current fill):
  - set when fill > HI_THRESH;
  - cleared when fill < LO_THRESH;
  - otherwise held.
- State machine:
  - LATCH:
    - dout=0; counter increments each cycle.
    - When the counter reaches T_RESET-1: go to IDLE and clear the counter.
    - If the post-frame flag is set, pulse frame_done for that cycle and clear the flag.
    - No pops occur in LATCH.
  - IDLE:
    - dout=0.
    - If fill>0: pop into shift register sh, set bitcnt=7 and symcnt=0, drive dout=1 next cycle, go to BIT.
  - BIT:
    - dout stays 1 while symcnt < (sh[bitcnt] ? T1H : T0H), then 0 for the rest of the symbol.
    - symcnt counts 0..T_BIT-1.
    - At symcnt==T_BIT-1 with bitcnt>0: decrement bitcnt and start the next symbol (dout=1).
    - At symcnt==T_BIT-1 with bitcnt==0:
      - if fill>0, pop the next byte in the same cycle and continue with no gap (dout=1 next cycle);
      - otherwise (underrun) set the post-frame flag and go to LATCH with counter 0, dout=0.
- Timing guarantees:
  - Every symbol period is exactly T_BIT cycles.
  - High time is exactly T0H or T1H cycles.
  - Consecutive bytes within a frame are contiguous.
  - Any empty FIFO at a byte boundary ends the frame; late data starts a new frame only after the full latch.
- busy = (state != IDLE). It is 1 during the power-up latch.

Test Plan:
1. Release rst and push 0xA5 at cycle 0 → dout stays 0 for 1024 cycles (no frame_done). The first rising edge is at cycle 1025 ±1. High widths are 10,5,10,5,5,10,5,10 at a 16-cycle period. Then 1024 low cycles and a single frame_done pulse.
2. During the initial latch, push 0x00,0xFF,0x81 → 24 contiguous symbols over 384 cycles with no gap at byte boundaries; one frame_done pulse 1024 cycles after the last symbol.
3. During the initial latch, push 21 bytes → throttle rises one cycle after fill=21. After the latch, draining lowers it only after fill reaches 9; it stays high at fill 10..20.
4. During the initial latch, hold in_valid for 40 cycles → exactly 32 bytes accepted, in_ready=0 at fill=32, fill never exceeds 32. Pointer wrap is checked by a subsequent drain-and-refill of 32 bytes in order.
5. Push 0x0F, then 0xF0 arriving 20 cycles after 0x0F's last symbol ends → 0x0F frame ends, 1024-cycle low latch, frame_done, then 0xF0 transmitted as a new frame.
6. Assert rst for 1 cycle mid-way through bit 3 of a byte with 5 bytes queued → dout=0 and fill=0 the next cycle. Throttle is 0. A new 1024-cycle latch completes without a frame_done pulse.
